// File: rtl/vital_pkg.sv
// rtl/vital_pkg.sv - shared types and constants for the vital threshold checker
package vital_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CMP_LO = 2'd1,
    S_CMP_HI = 2'd2,
    S_DONE   = 2'd3
  } vtc_state_t;

  typedef struct packed {
    logic l;
    logic e;
    logic g;
  } casc_t;

  localparam casc_t CASC_INIT = '{l: 1'b0, e: 1'b1, g: 1'b0};

endpackage

// File: rtl/vital_threshold_checker_cmp3_slice.sv
// rtl/vital_threshold_checker_cmp3_slice.sv - 3-bit cascadable magnitude comparator slice
module cmp3_slice
  import vital_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_l,
  input  logic               i_e,
  input  logic               i_g,
  output logic               o_lt,
  output logic               o_et,
  output logic               o_gt
);

  // Local difference wins; on equality the lower-order verdict passes through
  always_comb begin
    o_lt = i_l;
    o_et = i_e;
    o_gt = i_g;
    if (i_a > i_b) begin
      o_lt = 1'b0;
      o_et = 1'b0;
      o_gt = 1'b1;
    end else if (i_a < i_b) begin
      o_lt = 1'b1;
      o_et = 1'b0;
      o_gt = 1'b0;
    end
  end

endmodule

// File: rtl/vital_threshold_checker.sv
// rtl/vital_threshold_checker.sv - serial low/high range check using one shared 3-bit slice
module vital_threshold_checker
  import vital_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] th_low,
  input  logic [WIDTH-1:0] th_high,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             below,
  output logic             above,
  output logic             in_range
);

  localparam int NSL = WIDTH / SLICE_W;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

  vtc_state_t       r_state;
  logic [KW-1:0]    r_k;
  casc_t            r_casc;
  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_th_low;
  logic [WIDTH-1:0] r_th_high;
  logic             r_lo_lt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_below;
  logic             r_above;
  logic             r_in_range;

  logic [WIDTH-1:0]   w_b_word;
  logic [SLICE_W-1:0] w_a;
  logic [SLICE_W-1:0] w_b;
  casc_t              w_casc;

  // Pick the threshold for the active comparison and slice both operands at k
  always_comb begin
    w_b_word = (r_state == S_CMP_HI) ? r_th_high : r_th_low;
    w_a      = r_sample[r_k*SLICE_W +: SLICE_W];
    w_b      = w_b_word[r_k*SLICE_W +: SLICE_W];
  end

  cmp3_slice u_slice (
    .i_a  (w_a),
    .i_b  (w_b),
    .i_l  (r_casc.l),
    .i_e  (r_casc.e),
    .i_g  (r_casc.g),
    .o_lt (w_casc.l),
    .o_et (w_casc.e),
    .o_gt (w_casc.g)
  );

  // Controller: accept, walk slices LSB-first for low then high, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_casc      <= CASC_INIT;
      r_sample    <= '0;
      r_th_low    <= '0;
      r_th_high   <= '0;
      r_lo_lt     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_below     <= 1'b0;
      r_above     <= 1'b0;
      r_in_range  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sample   <= sample;
            r_th_low   <= th_low;
            r_th_high  <= th_high;
            r_k        <= '0;
            r_casc     <= CASC_INIT;
            r_in_ready <= 1'b0;
            r_state    <= S_CMP_LO;
          end
        end
        S_CMP_LO: begin
          if (r_k == K_LAST) begin
            r_lo_lt <= w_casc.l;
            r_casc  <= CASC_INIT;
            r_k     <= '0;
            r_state <= S_CMP_HI;
          end else begin
            r_casc <= w_casc;
            r_k    <= r_k + 1'b1;
          end
        end
        S_CMP_HI: begin
          if (r_k == K_LAST) begin
            r_below     <= r_lo_lt;
            r_above     <= w_casc.g;
            r_in_range  <= !r_lo_lt && !w_casc.g;
            r_out_valid <= 1'b1;
            r_casc      <= CASC_INIT;
            r_k         <= '0;
            r_state     <= S_DONE;
          end else begin
            r_casc <= w_casc;
            r_k    <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_below     <= 1'b0;
            r_above     <= 1'b0;
            r_in_range  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign below     = r_below;
  assign above     = r_above;
  assign in_range  = r_in_range;

endmodule

// File: tb/tb_vital_threshold_checker.sv
// tb/tb_vital_threshold_checker.sv - randomized self-checking bench for vital_threshold_checker
module tb_vital_threshold_checker;

  localparam int WIDTH = 12;
  localparam int LAT   = 2 * (WIDTH / 3);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] th_low;
  logic [WIDTH-1:0] th_high;
  logic             out_valid;
  logic             out_ready;
  logic             below;
  logic             above;
  logic             in_range;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vital_threshold_checker #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sample    (sample),
    .th_low    (th_low),
    .th_high   (th_high),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .below     (below),
    .above     (above),
    .in_range  (in_range)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    sample  = WIDTH'($urandom);
    th_low  = WIDTH'($urandom);
    th_high = WIDTH'($urandom);
  endtask

  // One full transaction; the expected flags come straight from the range definition
  task automatic run_txn(input int s, input int lo, input int hi, input int bp);
    int lat;
    int wait_cnt;
    int e_below, e_above, e_in;
    e_below = (s < lo) ? 1 : 0;
    e_above = (s > hi) ? 1 : 0;
    e_in    = (!e_below && !e_above) ? 1 : 0;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    check("in_ready_before_accept", int'(in_ready), 1);
    out_ready = (bp == 0);
    sample    = WIDTH'(s);
    th_low    = WIDTH'(lo);
    th_high   = WIDTH'(hi);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    scramble_inputs();
    check("in_ready_busy", int'(in_ready), 0);
    lat = 1;
    check("flags_zero_busy", int'({below, above, in_range}), 0);
    while (!out_valid && lat < 50) begin
      tick();
      if (!out_valid) check("in_ready_busy_wait", int'(in_ready), 0);
      lat = lat + (out_valid ? 0 : 1);
    end
    check("latency", lat, LAT);
    check("below", int'(below), e_below);
    check("above", int'(above), e_above);
    check("in_range", int'(in_range), e_in);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      scramble_inputs();
      tick();
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_flags", int'({below, above, in_range}), (e_below << 2) | (e_above << 1) | e_in);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("out_valid_drop", int'(out_valid), 0);
    check("in_ready_back", int'(in_ready), 1);
    check("flags_cleared", int'({below, above, in_range}), 0);
  endtask

  int pick;
  int rs, rlo, rhi;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sample    = '0;
    th_low    = '0;
    th_high   = '0;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_flags", int'({below, above, in_range}), 0);
    rst_n = 1'b1;
    tick();

    run_txn(100, 60, 120, 0);
    run_txn(50, 60, 120, 0);
    run_txn(200, 60, 120, 0);
    run_txn(60, 60, 120, 0);
    run_txn(120, 60, 120, 0);
    run_txn(59, 60, 120, 0);
    run_txn(4095, 0, 4094, 0);
    run_txn(100, 60, 120, 5);
    run_txn(120, 150, 100, 0);

    // Reset while the high comparison is in flight
    out_ready = 1'b1;
    sample    = 12'd50;
    th_low    = 12'd60;
    th_high   = 12'd120;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("midrst_no_result", int'(out_valid), 0);
    end
    run_txn(130, 60, 120, 0);

    for (int n = 0; n < 40; n++) begin
      rlo  = int'($urandom_range(0, 4095));
      rhi  = int'($urandom_range(0, 4095));
      pick = int'($urandom_range(0, 5));
      case (pick)
        0: rs = rlo;
        1: rs = rhi;
        2: rs = (rlo > 0) ? rlo - 1 : 0;
        3: rs = (rhi < 4095) ? rhi + 1 : 4095;
        default: rs = int'($urandom_range(0, 4095));
      endcase
      run_txn(rs, rlo, rhi, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
